ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.
//  Runs the full sequence: clock inhibit, request-to-send, 8 data bits LSB first, odd parity, stop, device ACK.
//  Drives the open-drain PS2Clk/PS2Data lines through active-high pull-low enables; the top level builds the tristates.
//  Sits beside PS2Receiver; tx_active tells the receiver to discard frames while a send is in progress.
// PARAMETERS
//  INHIBIT_CYC   12000     clk cycles PS2Clk is held low before the request (120 us at 100 MHz)
//  REQ_CYC       200       clk cycles both lines are held low before PS2Clk is released
//  START_TO_CYC  1500000   max clk cycles from PS2Clk release to the first device falling edge (15 ms)
//  PKT_TO_CYC    200000    max clk cycles from the first falling edge to the ACK (2 ms)
//  FILT_LEN      8         consecutive equal samples needed to accept a new PS2Clk level (glitch filter)
// PORTS
//  clk        in   1  system clock (100 MHz)
//  rst        in   1  synchronous reset, active high
//  start      in   1  1-cycle request to send; accepted only while ready=1
//  tdata      in   8  command byte, captured on the accepted start
//  ready      out  1  idle; a new start is accepted
//  tx_active  out  1  high from the accepted start until done/err
//  done       out  1  1-cycle pulse: byte sent and ACK seen (data low on the 11th falling edge)
//  err        out  1  1-cycle pulse: timeout or missing ACK
//  kclk_in    in   1  raw PS2Clk level (asynchronous)
//  kdata_in   in   1  raw PS2Data level (asynchronous)
//  kclk_oe    out  1  1 = pull PS2Clk low
//  kdata_oe   out  1  1 = pull PS2Data low
// BEHAVIOUR
//  - Reset: state=IDLE, ready=1, tx_active=0, done=0, err=0, kclk_oe=0, kdata_oe=0, all counters=0.
//  - kclk_in and kdata_in pass through a 2-FF synchroniser.
//  - Clock filter: the filtered kclk changes only after FILT_LEN equal synchronised samples.
//  - fall = 1-cycle strobe on a filtered 1->0 transition.
//  - Frame shift register holds {stop=1, parity=~^tdata, tdata}; bit index 0..9.
//  - IDLE: when start=1, capture tdata, ready<=0, tx_active<=1, go to INHIBIT. start while ready=0 is ignored.
//  - INHIBIT: kclk_oe=1 for INHIBIT_CYC cycles, then go to REQ.
//  - REQ: kclk_oe=1 and kdata_oe=1 (the start bit) for REQ_CYC cycles.
//    Then release kclk_oe, clear the timer, go to WAIT_CLK.
//  - WAIT_CLK: on the first fall, drive kdata_oe=~bit[0], set idx=1, go to SEND.
//    If START_TO_CYC elapses first, go to ERR.
//  - SEND: on each fall, drive kdata_oe=~bit[idx], idx++.
//    The fall that presents idx 9 releases the data line (stop bit), then go to ACK.
//    Data changes only in the cycle after a fall; the device samples on its rising edge.
//  - ACK: on the next fall (the 11th overall), sample synchronised kdata.
//    kdata=0: go to RELEASE. kdata=1: go to ERR.
//  - RELEASE: wait until filtered kclk=1 and synchronised kdata=1, then go to DONE.
//  - PKT_TO_CYC counts from the first fall through RELEASE; expiry in SEND, ACK or RELEASE goes to ERR.
//  - DONE: done=1 for 1 cycle, then IDLE (ready=1, tx_active=0).
//  - ERR: err=1 for 1 cycle, both oe=0, then IDLE.
//  - From request to DONE/ERR there are 11 falls; an 11th fall arriving early cannot occur by construction.
//    Falls arriving in IDLE/INHIBIT/REQ are ignored.
//  - rst mid-frame: both oe drop in the same cycle as reset takes effect; no done/err pulse.
//  - Timers are saturating, wide enough for max(INHIBIT_CYC, START_TO_CYC, PKT_TO_CYC).
//  - done and err are never asserted in the same cycle.
// CONFIGURATION
//  PS2_TX_RETRY_EN defined:
//    - on a timeout or missing ACK, restart from INHIBIT with the same byte, up to 2 retries.
//    - err pulses only after the third failure.
//    - tx_active stays high across retries.
//  PS2_TX_RETRY_EN undefined: the first failure goes straight to ERR. No retry counter is synthesised.
// TESTING
//  1. tdata=0xED, start: kclk_oe low 12000 cyc, then both low 200 cyc.
//     Device model clocks 11 falls at 12 kHz and ACKs: data bits 1,0,1,1,0,1,1,1, parity 1, stop 1; done=1 once.
//  2. tdata=0x00: parity bit=1. tdata=0x07: parity bit=0.
//     kdata_oe pattern checked per fall; ready returns 1 the cycle after done.
//  3. Device never clocks: err pulses START_TO_CYC cycles after release (no macro).
//     With PS2_TX_RETRY_EN, 3 full attempts are seen before err.
//  4. Device leaves data high on the 11th fall (NACK): err=1, both oe=0, done never asserted.
//  5. 2-cycle glitches on kclk_in during SEND: no extra bit advance; the frame is still correct and ACKed.
//  6. rst asserted after the 5th fall: next cycle kclk_oe=kdata_oe=0, ready=1, no pulses.
//     A new start then completes normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits, odd parity, stop, device ACK.
// Optional macro PS2_TX_RETRY_EN: retry a failed frame up to twice before flagging err.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYC  = 12000,
    parameter int unsigned REQ_CYC      = 200,
    parameter int unsigned START_TO_CYC = 1500000,
    parameter int unsigned PKT_TO_CYC   = 200000,
    parameter int unsigned FILT_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tdata,
    output logic       ready,
    output logic       tx_active,
    output logic       done,
    output logic       err,
    input  logic       kclk_in,
    input  logic       kdata_in,
    output logic       kclk_oe,
    output logic       kdata_oe
);

    localparam int unsigned MAX_AB  = (INHIBIT_CYC > REQ_CYC) ? INHIBIT_CYC : REQ_CYC;
    localparam int unsigned MAX_CD  = (START_TO_CYC > PKT_TO_CYC) ? START_TO_CYC : PKT_TO_CYC;
    localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned TW      = $clog2(MAX_CYC + 1);
    localparam int unsigned FW      = $clog2(FILT_LEN + 1);

    typedef enum logic [3:0] {
        IDLE, INHIBIT, REQ, WAIT_CLK, SEND, ACK, RELEASE, DONE, ERR
    } state_t;

    state_t          state;
    logic            kclk_s1, kclk_s2, kdata_s1, kdata_s2;
    logic            kclk_f;
    logic [FW-1:0]   filt_cnt;
    logic            fall;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_inc;
    logic [3:0]      idx;
    logic [9:0]      frame;
    logic            timeout_c;
    logic            nack_c;
    logic            fail_c;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]      retry_cnt;
`endif

    // Synchronise both lines; the clock level is accepted only after FILT_LEN equal samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            kclk_s1  <= 1'b1;
            kclk_s2  <= 1'b1;
            kdata_s1 <= 1'b1;
            kdata_s2 <= 1'b1;
            kclk_f   <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            kclk_s1  <= kclk_in;
            kclk_s2  <= kclk_s1;
            kdata_s1 <= kdata_in;
            kdata_s2 <= kdata_s1;
            fall     <= 1'b0;
            if (kclk_s2 == kclk_f) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
                kclk_f   <= kclk_s2;
                filt_cnt <= '0;
                fall     <= ~kclk_s2;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    assign timer_inc = (timer == {TW{1'b1}}) ? timer : timer + TW'(1);

    // Failure detection: start/packet timeouts and a missing ACK on the 11th fall.
    always_comb begin
        timeout_c = 1'b0;
        case (state)
            WAIT_CLK:          timeout_c = !fall && (timer >= TW'(START_TO_CYC - 1));
            SEND, ACK, RELEASE: timeout_c = (timer >= TW'(PKT_TO_CYC - 1));
            default:           timeout_c = 1'b0;
        endcase
        nack_c = (state == ACK) && fall && kdata_s2;
        fail_c = timeout_c | nack_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ready     <= 1'b1;
            tx_active <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            kclk_oe   <= 1'b0;
            kdata_oe  <= 1'b0;
            timer     <= '0;
            idx       <= '0;
            frame     <= '0;
`ifdef PS2_TX_RETRY_EN
            retry_cnt <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (fail_c) begin
`ifdef PS2_TX_RETRY_EN
                if (retry_cnt != 2'd2) begin
                    retry_cnt <= retry_cnt + 2'd1;
                    kclk_oe   <= 1'b1;
                    kdata_oe  <= 1'b0;
                    timer     <= '0;
                    state     <= INHIBIT;
                end else
`endif
                begin
                    err      <= 1'b1;
                    kclk_oe  <= 1'b0;
                    kdata_oe <= 1'b0;
                    state    <= ERR;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            frame     <= {1'b1, ~^tdata, tdata};
                            ready     <= 1'b0;
                            tx_active <= 1'b1;
                            kclk_oe   <= 1'b1;
                            timer     <= '0;
`ifdef PS2_TX_RETRY_EN
                            retry_cnt <= '0;
`endif
                            state     <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (timer == TW'(INHIBIT_CYC - 1)) begin
                            timer    <= '0;
                            kdata_oe <= 1'b1;
                            state    <= REQ;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                    REQ: begin
                        if (timer == TW'(REQ_CYC - 1)) begin
                            timer   <= '0;
                            kclk_oe <= 1'b0;
                            state   <= WAIT_CLK;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                    WAIT_CLK: begin
                        if (fall) begin
                            kdata_oe <= ~frame[0];
                            idx      <= 4'd1;
                            timer    <= '0;
                            state    <= SEND;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                    SEND: begin
                        // idx 9 is the stop bit: it releases the data line.
                        timer <= timer_inc;
                        if (fall) begin
                            kdata_oe <= ~frame[idx];
                            idx      <= idx + 4'd1;
                            if (idx == 4'd9) state <= ACK;
                        end
                    end
                    ACK: begin
                        timer <= timer_inc;
                        if (fall) state <= RELEASE;
                    end
                    RELEASE: begin
                        timer <= timer_inc;
                        if (kclk_f && kdata_s2) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                    DONE, ERR: begin
                        ready     <= 1'b1;
                        tx_active <= 1'b0;
                        kclk_oe   <= 1'b0;
                        kdata_oe  <= 1'b0;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames; expected frames are queued at start and popped per frame.
module tb_ps2_host_tx;

    localparam int unsigned INH   = 120;
    localparam int unsigned REQC  = 20;
    localparam int unsigned STO   = 2000;
    localparam int unsigned PTO   = 3000;
    localparam int unsigned FILT  = 8;
    localparam int          HALF  = 40;
    localparam int          LIM   = 4 * (INH + REQC + STO) + 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] tdata = 8'h00;
    logic       ready, tx_active, done, err;
    logic       kclk_oe, kdata_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       kclk_in, kdata_in;

    int n_pass = 0;
    int n_total = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    logic [9:0] exp_q[$];

    assign kclk_in  = dev_clk & ~kclk_oe;
    assign kdata_in = dev_data & ~kdata_oe;

    ps2_host_tx #(
        .INHIBIT_CYC (INH),
        .REQ_CYC     (REQC),
        .START_TO_CYC(STO),
        .PKT_TO_CYC  (PTO),
        .FILT_LEN    (FILT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .tdata    (tdata),
        .ready    (ready),
        .tx_active(tx_active),
        .done     (done),
        .err      (err),
        .kclk_in  (kclk_in),
        .kdata_in (kdata_in),
        .kclk_oe  (kclk_oe),
        .kdata_oe (kdata_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (err) err_cnt <= err_cnt + 1;
        if (done && err) both_cnt <= both_cnt + 1;
    end

    task automatic send_start(input logic [7:0] d);
        @(negedge clk);
        tdata = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_q.push_back({1'b1, ~^d, d});
    endtask

    // Device: wait for request-to-send, clock 11 falls, sample host data after each rise.
    task automatic dev_frame(input bit ack, input bit glitch, input int abort_after,
                             output logic [9:0] bits);
        int n;
        bits = '1;
        n = 0;
        while (!(kclk_oe == 1'b0 && kdata_oe == 1'b1) && n < LIM) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (n >= LIM) $display("FAIL req_wait: waited %0d cycles, limit %0d", n, LIM);
        else n_pass++;
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) dev_data = ack ? 1'b0 : 1'b1;
            for (int c = 0; c < HALF; c++) begin
                @(negedge clk);
                if (glitch && k > 1 && c == HALF / 2) dev_clk = 1'b0;
                else if (glitch && k > 1 && c == HALF / 2 + 2) dev_clk = 1'b1;
            end
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (k == abort_after) return;
            if (k <= 10) begin
                @(negedge clk);
                bits[k-1] = kdata_in;
            end
        end
        dev_data = 1'b1;
    endtask

    task automatic finish_frame(input string name);
        int n;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (!done) $display("FAIL %s_done: done=%0b after %0d cycles, expected 1", name, done, n);
        else n_pass++;
        n_total++;
        if (ready !== 1'b0) $display("FAIL %s_ready_in_done: ready=%0b expected 0", name, ready);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (ready !== 1'b1 || tx_active !== 1'b0)
            $display("FAIL %s_ready_after: ready=%0b tx_active=%0b expected 1/0", name, ready, tx_active);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if ({ready, tx_active, done, err} !== 4'b1000)
            $display("FAIL reset_flags: got %b expected 1000", {ready, tx_active, done, err});
        else n_pass++;
        n_total++;
        if ({kclk_oe, kdata_oe} !== 2'b00)
            $display("FAIL reset_oe: got %b expected 00", {kclk_oe, kdata_oe});
        else n_pass++;
    endtask

    task automatic test_led_cmd;
        int n;
        int d0;
        logic [9:0] bits, exp;
        d0 = done_cnt;
        send_start(8'hED);
        n = 0;
        while (kclk_oe && !kdata_oe && n < LIM) begin @(negedge clk); n++; end
        n_total++;
        if (n != INH) $display("FAIL inhibit_len: got %0d expected %0d", n, INH);
        else n_pass++;
        n = 0;
        while (kclk_oe && kdata_oe && n < LIM) begin @(negedge clk); n++; end
        n_total++;
        if (n != REQC) $display("FAIL req_len: got %0d expected %0d", n, REQC);
        else n_pass++;
        n_total++;
        if (tx_active !== 1'b1 || ready !== 1'b0)
            $display("FAIL led_active: tx_active=%0b ready=%0b expected 1/0", tx_active, ready);
        else n_pass++;
        dev_frame(1'b1, 1'b0, 0, bits);
        exp = exp_q.pop_front();
        n_total++;
        if (bits !== exp) $display("FAIL led_frame: got %b expected %b", bits, exp);
        else n_pass++;
        n_total++;
        if (exp !== 10'b11_1110_1101) $display("FAIL led_model: got %b expected 1111101101", exp);
        else n_pass++;
        finish_frame("led");
        repeat (20) @(negedge clk);
        n_total++;
        if (done_cnt - d0 != 1) $display("FAIL led_done_once: got %0d pulses expected 1", done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_parity;
        logic [7:0] pats[2];
        logic [9:0] bits, exp;
        pats[0] = 8'h00;
        pats[1] = 8'h07;
        for (int p = 0; p < 2; p++) begin
            send_start(pats[p]);
            dev_frame(1'b1, 1'b0, 0, bits);
            exp = exp_q.pop_front();
            for (int b = 0; b < 10; b++) begin
                n_total++;
                if (bits[b] !== exp[b])
                    $display("FAIL parity_%02h_bit%0d: got %0b expected %0b", pats[p], b, bits[b], exp[b]);
                else n_pass++;
            end
            n_total++;
            if (bits[8] !== (p == 0 ? 1'b1 : 1'b0))
                $display("FAIL parity_%02h: got %0b", pats[p], bits[8]);
            else n_pass++;
            finish_frame("parity");
        end
    endtask

    task automatic test_start_timeout;
        int n;
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_start(8'hFF);
        void'(exp_q.pop_front());
`ifdef PS2_TX_RETRY_EN
        begin
            int attempts;
            logic prev;
            attempts = 1;
            prev = kclk_oe;
            n = 0;
            while (!err && n < LIM) begin
                @(negedge clk);
                if (kclk_oe && !prev) attempts++;
                prev = kclk_oe;
                n++;
            end
            n_total++;
            if (attempts != 3) $display("FAIL timeout_attempts: got %0d expected 3", attempts);
            else n_pass++;
        end
`else
        n = 0;
        while (!(kclk_oe == 1'b0 && kdata_oe == 1'b1) && n < LIM) begin @(negedge clk); n++; end
        n = 0;
        while (!err && n < LIM) begin @(negedge clk); n++; end
        n_total++;
        if (n != STO) $display("FAIL start_timeout_len: got %0d expected %0d", n, STO);
        else n_pass++;
`endif
        n_total++;
        if (err !== 1'b1 || {kclk_oe, kdata_oe} !== 2'b00)
            $display("FAIL timeout_err: err=%0b oe=%b expected 1/00", err, {kclk_oe, kdata_oe});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (err !== 1'b0 || ready !== 1'b1 || done_cnt != d0 || err_cnt - e0 != 1)
            $display("FAIL timeout_after: err=%0b ready=%0b dones=%0d errs=%0d", err, ready,
                     done_cnt - d0, err_cnt - e0);
        else n_pass++;
    endtask

    task automatic test_nack;
        logic [9:0] bits, exp;
        int d0, e0, attempts;
        d0 = done_cnt;
        e0 = err_cnt;
`ifdef PS2_TX_RETRY_EN
        attempts = 3;
`else
        attempts = 1;
`endif
        send_start(8'hF4);
        exp = exp_q.pop_front();
        for (int a = 0; a < attempts; a++) begin
            dev_frame(1'b0, 1'b0, 0, bits);
            if (a == 0) begin
                n_total++;
                if (bits !== exp) $display("FAIL nack_frame: got %b expected %b", bits, exp);
                else n_pass++;
            end
        end
        repeat (5) @(negedge clk);
        n_total++;
        if (err_cnt - e0 != 1 || done_cnt != d0)
            $display("FAIL nack_pulses: errs=%0d dones=%0d expected 1/0", err_cnt - e0, done_cnt - d0);
        else n_pass++;
        n_total++;
        if ({kclk_oe, kdata_oe, ready} !== 3'b001)
            $display("FAIL nack_idle: oe=%b ready=%0b expected 00/1", {kclk_oe, kdata_oe}, ready);
        else n_pass++;
    endtask

    task automatic test_glitch;
        logic [9:0] bits, exp;
        send_start(8'hA5);
        dev_frame(1'b1, 1'b1, 0, bits);
        exp = exp_q.pop_front();
        n_total++;
        if (bits !== exp) $display("FAIL glitch_frame: got %b expected %b", bits, exp);
        else n_pass++;
        finish_frame("glitch");
    endtask

    task automatic test_reset_midframe;
        logic [9:0] bits, exp;
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_start(8'h3C);
        void'(exp_q.pop_front());
        dev_frame(1'b1, 1'b0, 5, bits);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++;
        if ({kclk_oe, kdata_oe, ready, tx_active} !== 4'b0010)
            $display("FAIL midreset_state: oe=%b ready=%0b tx_active=%0b expected 00/1/0",
                     {kclk_oe, kdata_oe}, ready, tx_active);
        else n_pass++;
        repeat (5) @(negedge clk);
        n_total++;
        if (done_cnt != d0 || err_cnt != e0)
            $display("FAIL midreset_pulses: dones=%0d errs=%0d expected 0/0", done_cnt - d0, err_cnt - e0);
        else n_pass++;
        send_start(8'h81);
        dev_frame(1'b1, 1'b0, 0, bits);
        exp = exp_q.pop_front();
        n_total++;
        if (bits !== exp) $display("FAIL midreset_next_frame: got %b expected %b", bits, exp);
        else n_pass++;
        finish_frame("midreset");
    endtask

    initial begin
        test_reset();
        test_led_cmd();
        test_parity();
        test_start_timeout();
        test_nack();
        test_glitch();
        test_reset_midframe();
        n_total++;
        if (both_cnt != 0) $display("FAIL done_err_overlap: got %0d cycles expected 0", both_cnt);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
